bus_time_serializer: RTL and testbench

- Parametrised successor of the 16-input bus-to-time-serial mux.
- Serialises NUM_INPUTS parallel BUS_WIDTH-bit words onto one bus. The channel index advances on select_line activity.
- Transition mode (rising, falling, pulse) is a run-time, gamma-cycle-latched control instead of a compile-time choice.
- Adds a gamma-cycle restart, a sticky wrap flag, a valid strobe and any (non-power-of-2) channel count.

---
 rtl/bus_time_serializer_pkg.sv | 26 ++
 rtl/mux_nto1.sv | 29 ++
 rtl/bus_time_serializer.sv | 120 ++++++++++++
 tb/tb_bus_time_serializer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/bus_time_serializer_pkg.sv
// ============================================================================
// Module  : bus_time_serializer_pkg
// Brief   : Shared types and helpers for the bus-to-time-serial multiplexer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_time_serializer_pkg;

  typedef enum logic [1:0] {
    MODE_RISE  = 2'b00,
    MODE_FALL  = 2'b01,
    MODE_PULSE = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;

  // A 1-input or 2-input mux still needs a 1-bit select.
  function automatic int idx_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux_nto1.sv
// ============================================================================
// Module  : mux_nto1
// Brief   : NUM_INPUTS-to-1 combinational word mux; out-of-range select -> 0.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_nto1 #(
  parameter int NUM_INPUTS = 16,
  parameter int BUS_WIDTH  = 8,
  parameter int SEL_W      = 4
) (
  input  logic [NUM_INPUTS*BUS_WIDTH-1:0] din,
  input  logic [SEL_W-1:0]                sel,
  output logic [BUS_WIDTH-1:0]            dout
);

  always_comb begin
    dout = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (sel == SEL_W'(i)) begin
        dout = din[i*BUS_WIDTH +: BUS_WIDTH];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bus_time_serializer.sv
// ============================================================================
// Module  : bus_time_serializer
// Brief   : Serialises NUM_INPUTS parallel words onto one bus, paced by
//           select_line, with a run-time transition mode latched per gamma
//           cycle. Optional macro BUS_TIME_SERIALIZER_SNAPSHOT_EN freezes the
//           source words on gamma_start.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_time_serializer
  import bus_time_serializer_pkg::*;
#(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int NUM_INPUTS        = GAMMA_CYCLE_WIDTH,
  parameter int BUS_WIDTH         = 8,
  parameter int IDX_W             = idx_width(NUM_INPUTS)
) (
  input  logic                            aclk,
  input  logic                            grst,
  input  logic [NUM_INPUTS*BUS_WIDTH-1:0] inputs,
  input  logic                            select_line,
  input  logic                            gamma_start,
  input  logic [1:0]                      mode,
  output logic [BUS_WIDTH-1:0]            y,
  output logic                            y_valid,
  output logic [IDX_W-1:0]                chan_idx,
  output logic                            wrapped
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);

  logic [IDX_W-1:0]                idx;
  logic                            sel_q;
  mode_e                           mode_q;
  logic                            valid_raw;
  logic                            advance;
  logic [BUS_WIDTH-1:0]            mux_out;
  logic [NUM_INPUTS*BUS_WIDTH-1:0] mux_src;

`ifdef BUS_TIME_SERIALIZER_SNAPSHOT_EN
  logic [NUM_INPUTS*BUS_WIDTH-1:0] snap;

  always_ff @(posedge aclk) begin
    if (grst) begin
      snap <= '0;
    end else if (gamma_start) begin
      snap <= inputs;
    end
  end

  assign mux_src = snap;
`else
  assign mux_src = inputs;
`endif

  always_comb begin
    valid_raw = 1'b0;
    advance   = 1'b0;
    case (mode_q)
      MODE_RISE: begin
        valid_raw = select_line;
        advance   = !select_line;
      end
      MODE_FALL: begin
        valid_raw = !select_line;
        advance   = select_line;
      end
      MODE_PULSE: begin
        valid_raw = select_line;
        advance   = sel_q && !select_line;
      end
      default: begin
        valid_raw = 1'b0;
        advance   = 1'b0;
      end
    endcase
  end

  // Gamma restart outranks an advance; sel_q keeps tracking regardless.
  always_ff @(posedge aclk) begin
    if (grst) begin
      idx     <= '0;
      sel_q   <= 1'b0;
      mode_q  <= MODE_RISE;
      wrapped <= 1'b0;
    end else begin
      sel_q <= select_line;
      if (gamma_start) begin
        idx     <= '0;
        wrapped <= 1'b0;
        mode_q  <= mode_e'(mode);
      end else if (advance) begin
        if (idx == LAST_IDX) begin
          idx     <= '0;
          wrapped <= 1'b1;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

  mux_nto1 #(
    .NUM_INPUTS (NUM_INPUTS),
    .BUS_WIDTH  (BUS_WIDTH),
    .SEL_W      (IDX_W)
  ) u_mux (
    .din  (mux_src),
    .sel  (idx),
    .dout (mux_out)
  );

  assign y_valid  = valid_raw && !grst;
  assign y        = y_valid ? mux_out : '0;
  assign chan_idx = idx;

endmodule

`default_nettype wire

// File: tb/tb_bus_time_serializer.sv
// ============================================================================
// Module  : tb_bus_time_serializer
// Brief   : Scoreboard bench for bus_time_serializer (16- and 5-channel DUTs).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_time_serializer;

`ifdef BUS_TIME_SERIALIZER_SNAPSHOT_EN
  localparam bit SNAP = 1'b1;
`else
  localparam bit SNAP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          grst = 1'b1;
  logic          select_line = 1'b0;
  logic          gamma_start = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [127:0]  inputs16;
  logic [39:0]   inputs5;

  logic [7:0]    y16, y5;
  logic          yv16, yv5;
  logic [3:0]    idx16;
  logic [2:0]    idx5;
  logic          wr16, wr5;

  typedef struct {
    int         dut;
    int         idx;
    bit         wr;
    logic [7:0] y;
    bit         yv;
    string      name;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  bus_time_serializer dut16 (
    .aclk(clk), .grst(grst), .inputs(inputs16), .select_line(select_line),
    .gamma_start(gamma_start), .mode(mode), .y(y16), .y_valid(yv16),
    .chan_idx(idx16), .wrapped(wr16)
  );

  bus_time_serializer #(.NUM_INPUTS(5)) dut5 (
    .aclk(clk), .grst(grst), .inputs(inputs5), .select_line(select_line),
    .gamma_start(gamma_start), .mode(mode), .y(y5), .y_valid(yv5),
    .chan_idx(idx5), .wrapped(wr5)
  );

  task automatic chk(input string nm, input string field, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s.%s actual=%0h required=%0h", nm, field, act, req);
    end
  endtask

  // Monitor: compares whatever the DUT presents this cycle against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.dut == 16) begin
          chk(e.name, "idx", int'(idx16), e.idx);
          chk(e.name, "wrapped", int'(wr16), int'(e.wr));
          chk(e.name, "y", int'(y16), int'(e.y));
          chk(e.name, "y_valid", int'(yv16), int'(e.yv));
        end else begin
          chk(e.name, "idx", int'(idx5), e.idx);
          chk(e.name, "wrapped", int'(wr5), int'(e.wr));
          chk(e.name, "y", int'(y5), int'(e.y));
          chk(e.name, "y_valid", int'(yv5), int'(e.yv));
        end
      end
    end
  end

  task automatic tick(input logic s, input logic g, input logic [1:0] m, input logic r);
    @(posedge clk);
    #1;
    select_line = s;
    gamma_start = g;
    mode        = m;
    grst        = r;
  endtask

  task automatic expect_now(input int d, input int i, input bit w, input logic [7:0] yy,
                            input bit v, input string nm);
    exp_t e;
    e.dut = d; e.idx = i; e.wr = w; e.y = yy; e.yv = v; e.name = nm;
    q.push_back(e);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) inputs16[i*8 +: 8] = 8'(8'h10 + i);
    for (int i = 0; i < 5; i++)  inputs5[i*8 +: 8]  = 8'(8'hA0 + i);

    // RISE stepping on the 16-channel DUT
    tick(0, 0, 2'b00, 1); expect_now(16, 0, 0, 8'h00, 0, "reset");
    tick(0, 1, 2'b00, 0); expect_now(16, 0, 0, 8'h00, 0, "rise_gs");
    tick(0, 0, 2'b00, 0); expect_now(16, 0, 0, 8'h00, 0, "rise_i0");
    tick(0, 0, 2'b00, 0); expect_now(16, 1, 0, 8'h00, 0, "rise_i1");
    tick(0, 0, 2'b00, 0); expect_now(16, 2, 0, 8'h00, 0, "rise_i2");
    tick(1, 0, 2'b00, 0); expect_now(16, 3, 0, 8'h13, 1, "rise_i3");
    tick(1, 0, 2'b00, 0); expect_now(16, 3, 0, 8'h13, 1, "rise_hold");

    // Mode change without gamma_start is ignored; gamma_start beats advance
    tick(1, 0, 2'b01, 0); expect_now(16, 3, 0, 8'h13, 1, "modechg_a");
    tick(0, 0, 2'b01, 0); expect_now(16, 3, 0, 8'h00, 0, "modechg_b");
    tick(0, 1, 2'b01, 0); expect_now(16, 4, 0, 8'h00, 0, "gs_vs_adv");
    tick(1, 0, 2'b00, 0); expect_now(16, 0, 0, 8'h00, 0, "fall_latched");
    tick(0, 0, 2'b00, 0); expect_now(16, 1, 0, 8'h11, 1, "fall_adv");

    // PULSE: three 2-wide pulses with 1 low cycle between
    tick(0, 1, 2'b10, 0); expect_now(16, 1, 0, 8'h11, 1, "pulse_gs");
    tick(1, 0, 2'b10, 0); expect_now(16, 0, 0, 8'h10, 1, "p1a");
    tick(1, 0, 2'b10, 0); expect_now(16, 0, 0, 8'h10, 1, "p1b");
    tick(0, 0, 2'b10, 0); expect_now(16, 0, 0, 8'h00, 0, "gap1");
    tick(1, 0, 2'b10, 0); expect_now(16, 1, 0, 8'h11, 1, "p2a");
    tick(1, 0, 2'b10, 0); expect_now(16, 1, 0, 8'h11, 1, "p2b");
    tick(0, 0, 2'b10, 0); expect_now(16, 1, 0, 8'h00, 0, "gap2");
    tick(1, 0, 2'b10, 0); expect_now(16, 2, 0, 8'h12, 1, "p3a");
    tick(1, 0, 2'b10, 0); expect_now(16, 2, 0, 8'h12, 1, "p3b");
    tick(0, 0, 2'b10, 0); expect_now(16, 2, 0, 8'h00, 0, "gap3");
    tick(0, 0, 2'b10, 0); expect_now(16, 3, 0, 8'h00, 0, "p_after");

    // FALL with wrap on the 5-channel DUT
    tick(0, 1, 2'b01, 0);
    tick(1, 0, 2'b01, 0); expect_now(5, 0, 0, 8'h00, 0, "f5_start");
    tick(1, 0, 2'b01, 0); expect_now(5, 1, 0, 8'h00, 0, "f5_i1");
    tick(1, 0, 2'b01, 0); expect_now(5, 2, 0, 8'h00, 0, "f5_i2");
    tick(1, 0, 2'b01, 0); expect_now(5, 3, 0, 8'h00, 0, "f5_i3");
    tick(1, 0, 2'b01, 0); expect_now(5, 4, 0, 8'h00, 0, "f5_i4");
    tick(1, 0, 2'b01, 0); expect_now(5, 0, 1, 8'h00, 0, "f5_wrap");
    tick(0, 0, 2'b01, 0); expect_now(5, 1, 1, 8'hA1, 1, "f5_i1b");
    tick(0, 0, 2'b01, 0); expect_now(5, 1, 1, 8'hA1, 1, "f5_sticky");
    tick(0, 1, 2'b10, 0); expect_now(5, 1, 1, 8'hA1, 1, "f5_gs");
    tick(1, 0, 2'b10, 0); expect_now(5, 0, 0, 8'hA0, 1, "f5_cleared");

    // Eight PULSE falling edges: idx=3, wrapped=1, mode_q=PULSE
    tick(0, 0, 2'b10, 0);
    for (int k = 0; k < 7; k++) begin
      tick(1, 0, 2'b10, 0);
      tick(0, 0, 2'b10, 0);
    end
    tick(0, 0, 2'b10, 0); expect_now(5, 3, 1, 8'h00, 0, "pre_reset");
    tick(1, 0, 2'b00, 1); expect_now(5, 3, 1, 8'h00, 0, "in_reset");
    tick(1, 0, 2'b00, 0); expect_now(5, 0, 0, SNAP ? 8'h00 : 8'hA0, 1, "post_reset");
    tick(0, 0, 2'b00, 0); expect_now(5, 0, 0, 8'h00, 0, "rst_rise_a");
    tick(0, 0, 2'b00, 0); expect_now(5, 1, 0, 8'h00, 0, "rst_rise_b");
    tick(0, 0, 2'b00, 0); expect_now(5, 2, 0, 8'h00, 0, "rst_rise_c");

    // Source word changes after gamma_start: snapshot holds, live path follows
    tick(1, 1, 2'b00, 0);
    inputs16[7:0] = 8'hA5;
    tick(1, 0, 2'b00, 0);
    inputs16[7:0] = 8'h00;
    expect_now(16, 0, 0, SNAP ? 8'hA5 : 8'h00, 1, "snap_a");
    tick(1, 0, 2'b00, 0); expect_now(16, 0, 0, SNAP ? 8'hA5 : 8'h00, 1, "snap_b");

    @(posedge clk);
    @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
